// File: rtl/fft_r22sdf_twiddle_pkg.sv
// Shared constants and elaboration-time helpers for the radix-2^2 SDF
// twiddle stage: twiddle scaling, quadrant permutation, pipeline depth and
// the cos/sin word generators used to fill the twiddle ROM.
package fft_r22sdf_twiddle_pkg;

  // Default widths used by the interface when no override is given.
  localparam int DEFAULT_DATA_WIDTH    = 25;
  localparam int DEFAULT_TWIDDLE_WIDTH = 10;

  // Fixed pipeline depth: index register, ROM read, multiply, round/saturate.
  localparam int LATENCY = 4;

  // Quadrant q of the sub-transform uses exponent multiplier QUAD_PERM[q];
  // the order is bit-reversed because butterfly-II emits quadrants 0,2,1,3.
  localparam int QUAD_PERM [4] = '{0, 2, 1, 3};

  localparam real TWO_PI = 6.283185307179586;

  // Per-sample control bits that ride alongside the data pipeline.
  typedef struct packed {
    logic valid;
    logic last;
  } ctrl_t;

  // Fixed-point value of 1.0 for a twiddle word of width tw.
  function automatic int twiddle_one(input int tw);
    return 1 << (tw - 2);
  endfunction

  // Round to nearest, halves away from zero.
  function automatic int round_real(input real v);
    if (v >= 0.0) begin
      return $rtoi(v + 0.5);
    end
    return -$rtoi(-v + 0.5);
  endfunction

  // cos(2*pi*e/n) scaled to the twiddle word format.
  function automatic int twiddle_cos(input int e, input int n, input int tw);
    return round_real($itor(twiddle_one(tw)) * $cos(TWO_PI * $itor(e) / $itor(n)));
  endfunction

  // sin(2*pi*e/n) scaled to the twiddle word format; the datapath applies
  // the minus sign of W = cos - j*sin.
  function automatic int twiddle_sin(input int e, input int n, input int tw);
    return round_real($itor(twiddle_one(tw)) * $sin(TWO_PI * $itor(e) / $itor(n)));
  endfunction

endpackage

// File: rtl/fft_r22sdf_twiddle_if.sv
// Sample stream between butterfly-II and the twiddle multiplier stage.
// The master drives the input sample; the slave returns the twiddled sample.
interface fft_r22sdf_twiddle_if
  import fft_r22sdf_twiddle_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                         valid_i;
  logic signed [DATA_WIDTH-1:0] x_re_i;
  logic signed [DATA_WIDTH-1:0] x_im_i;

  logic                         valid_o;
  logic                         last_o;
  logic signed [DATA_WIDTH-1:0] z_re_o;
  logic signed [DATA_WIDTH-1:0] z_im_o;

  modport master (
    output valid_i, x_re_i, x_im_i,
    input  valid_o, last_o, z_re_o, z_im_o
  );

  modport slave (
    input  valid_i, x_re_i, x_im_i,
    output valid_o, last_o, z_re_o, z_im_o
  );

endinterface

// File: rtl/fft_twiddle_rom.sv
// Twiddle ROM for exponents 0 .. 3N/4-1. Contents are computed at
// elaboration from N and TWIDDLE_WIDTH; the read port is registered so the
// array maps onto block or distributed ROM.
module fft_twiddle_rom
  import fft_r22sdf_twiddle_pkg::*;
#(
  parameter int N             = 1024,
  parameter int TWIDDLE_WIDTH = DEFAULT_TWIDDLE_WIDTH
) (
  input  logic                            clk_i,
  input  logic [$clog2(3*N/4)-1:0]        addr,
  output logic signed [TWIDDLE_WIDTH-1:0] cos_word,
  output logic signed [TWIDDLE_WIDTH-1:0] sin_word
);

  localparam int DEPTH = 3 * N / 4;

  logic signed [TWIDDLE_WIDTH-1:0] cos_mem [DEPTH];
  logic signed [TWIDDLE_WIDTH-1:0] sin_mem [DEPTH];

  // One constant entry per exponent.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
    assign cos_mem[gi] = TWIDDLE_WIDTH'(twiddle_cos(gi, N, TWIDDLE_WIDTH));
    assign sin_mem[gi] = TWIDDLE_WIDTH'(twiddle_sin(gi, N, TWIDDLE_WIDTH));
  end

  // Registered read, no reset so the read register folds into the ROM.
  always_ff @(posedge clk_i) begin
    cos_word <= cos_mem[addr];
    sin_word <= sin_mem[addr];
  end

endmodule

// File: rtl/fft_r22sdf_twiddle.sv
// Twiddle multiplier between the two butterflies of a radix-2^2 SDF stage.
// Counts input beats to derive the sample index, looks up the twiddle for
// exponent m*perm(q), applies the complex product at full precision, then
// rounds half-up and saturates back to DATA_WIDTH. Fixed 4-cycle latency.
module fft_r22sdf_twiddle
  import fft_r22sdf_twiddle_pkg::*;
#(
  parameter int DATA_WIDTH    = 25,
  parameter int TWIDDLE_WIDTH = 10,
  parameter int N             = 1024
) (
  input  logic                clk_i,
  input  logic                rst_n,
  fft_r22sdf_twiddle_if.slave bus
);

  localparam int INDEX_W   = $clog2(N);
  localparam int ADDR_W    = $clog2(3 * N / 4);
  localparam int SHIFT     = TWIDDLE_WIDTH - 2;
  localparam int PROD_W    = DATA_WIDTH + TWIDDLE_WIDTH;
  localparam int SUM_W     = PROD_W + 1;
  localparam int ROUND_INT = twiddle_one(TWIDDLE_WIDTH) / 2;

  localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(N - 1);

  // Sample index and its decomposition into quadrant and offset.
  logic [INDEX_W-1:0] n_reg;
  logic [1:0]         quad;
  logic [INDEX_W-3:0] m_idx;
  logic [ADDR_W-1:0]  e_next;

  // Control pipeline: entry 0 is stage 1, entry LATENCY-1 drives the outputs.
  ctrl_t ctrl_reg [LATENCY];

  // Stage 1: captured sample and twiddle address.
  logic signed [DATA_WIDTH-1:0] a1_reg, b1_reg;
  logic [ADDR_W-1:0]            e1_reg;

  // Stage 2: sample aligned with the ROM output.
  logic signed [DATA_WIDTH-1:0]    a2_reg, b2_reg;
  logic signed [TWIDDLE_WIDTH-1:0] c2, s2;

  // Stage 3: the four partial products.
  logic signed [PROD_W-1:0] prod_ac_reg, prod_bs_reg, prod_bc_reg, prod_as_reg;

  // Stage 4: rounded and saturated result.
  logic signed [SUM_W-1:0]      re_sum_next, im_sum_next;
  logic signed [SUM_W-1:0]      re_shift_next, im_shift_next;
  logic signed [DATA_WIDTH-1:0] z_re_reg, z_im_reg;

  // Clamp a scaled sum into the output range; in range when every bit above
  // the output sign bit matches it.
  function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [SUM_W-1:0] v);
    logic [SUM_W-DATA_WIDTH:0] head;
    head = v[SUM_W-1:DATA_WIDTH-1];
    if ((&head) || !(|head)) begin
      return v[DATA_WIDTH-1:0];
    end else if (v[SUM_W-1]) begin
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
    return {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  // Beat counter: advances only on valid input, wraps naturally at N.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      n_reg <= '0;
    end else if (bus.valid_i) begin
      n_reg <= n_reg + INDEX_W'(1);
    end
  end

  // Exponent e = m * perm(q); never exceeds 3(N/4-1), inside the ROM.
  always_comb begin
    quad   = n_reg[INDEX_W-1 -: 2];
    m_idx  = n_reg[INDEX_W-3:0];
    e_next = ADDR_W'(int'(m_idx) * QUAD_PERM[quad]);
  end

  // Control bits follow the data through all four stages; reset drops
  // anything in flight and ignores a beat presented during reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        ctrl_reg[i] <= '0;
      end
    end else begin
      ctrl_reg[0] <= ctrl_t'{valid: bus.valid_i, last: bus.valid_i && (n_reg == LAST_INDEX)};
      for (int i = 1; i < LATENCY; i++) begin
        ctrl_reg[i] <= ctrl_reg[i-1];
      end
    end
  end

  // Stage 1/2 data: capture the sample and address, then align the sample
  // with the registered ROM output.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      a1_reg <= '0;
      b1_reg <= '0;
      e1_reg <= '0;
      a2_reg <= '0;
      b2_reg <= '0;
    end else begin
      a1_reg <= bus.x_re_i;
      b1_reg <= bus.x_im_i;
      e1_reg <= e_next;
      a2_reg <= a1_reg;
      b2_reg <= b1_reg;
    end
  end

  fft_twiddle_rom #(
    .N             (N),
    .TWIDDLE_WIDTH (TWIDDLE_WIDTH)
  ) u_rom (
    .clk_i    (clk_i),
    .addr     (e1_reg),
    .cos_word (c2),
    .sin_word (s2)
  );

  // Stage 3: plain signed products, each into its own register.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      prod_ac_reg <= '0;
      prod_bs_reg <= '0;
      prod_bc_reg <= '0;
      prod_as_reg <= '0;
    end else begin
      prod_ac_reg <= PROD_W'(a2_reg) * PROD_W'(c2);
      prod_bs_reg <= PROD_W'(b2_reg) * PROD_W'(s2);
      prod_bc_reg <= PROD_W'(b2_reg) * PROD_W'(c2);
      prod_as_reg <= PROD_W'(a2_reg) * PROD_W'(s2);
    end
  end

  // Combine products for (a+jb)(c-js), add the half-LSB, scale back down.
  always_comb begin
    re_sum_next   = SUM_W'(prod_ac_reg) + SUM_W'(prod_bs_reg) + SUM_W'(ROUND_INT);
    im_sum_next   = SUM_W'(prod_bc_reg) - SUM_W'(prod_as_reg) + SUM_W'(ROUND_INT);
    re_shift_next = re_sum_next >>> SHIFT;
    im_shift_next = im_sum_next >>> SHIFT;
  end

  // Stage 4: saturated output registers, cleared during reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      z_re_reg <= '0;
      z_im_reg <= '0;
    end else begin
      z_re_reg <= saturate(re_shift_next);
      z_im_reg <= saturate(im_shift_next);
    end
  end

  assign bus.valid_o = ctrl_reg[LATENCY-1].valid;
  assign bus.last_o  = ctrl_reg[LATENCY-1].valid && ctrl_reg[LATENCY-1].last;
  assign bus.z_re_o  = z_re_reg;
  assign bus.z_im_o  = z_im_reg;

endmodule

// File: tb/tb_fft_r22sdf_twiddle.sv
// Directed and randomised checks of the twiddle stage with N=16,
// DATA_WIDTH=25, TWIDDLE_WIDTH=10 (1.0 = 256).
module tb_fft_r22sdf_twiddle;

  localparam int DW = 25;
  localparam int TW = 10;
  localparam int NN = 16;
  localparam longint MAXV = 16777215;
  localparam longint MINV = -16777216;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk_i = ~clk_i;

  fft_r22sdf_twiddle_if #(.DATA_WIDTH(DW)) bus ();

  fft_r22sdf_twiddle #(
    .DATA_WIDTH    (DW),
    .TWIDDLE_WIDTH (TW),
    .N             (NN)
  ) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected-output delay line, 4 deep to match the stage latency.
  logic   sh_v    [4];
  logic   sh_last [4];
  longint sh_re   [4];
  longint sh_im   [4];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_expect();
    for (int i = 0; i < 4; i++) begin
      sh_v[i] = 1'b0; sh_last[i] = 1'b0; sh_re[i] = 0; sh_im[i] = 0;
    end
  endtask

  // One clock: present a beat, then check whatever is due at the output.
  task automatic cycle(input logic v, input longint xre, input longint xim,
                       input longint ere, input longint eim, input logic elast);
    bus.valid_i = v;
    bus.x_re_i  = DW'(xre);
    bus.x_im_i  = DW'(xim);
    for (int i = 3; i > 0; i--) begin
      sh_v[i] = sh_v[i-1]; sh_last[i] = sh_last[i-1];
      sh_re[i] = sh_re[i-1]; sh_im[i] = sh_im[i-1];
    end
    sh_v[0] = v; sh_last[0] = elast; sh_re[0] = ere; sh_im[0] = eim;
    @(posedge clk_i); #1;
    cyc++;
    check("valid_o", longint'(bus.valid_o), longint'(sh_v[3]));
    check("last_o", longint'(bus.last_o), longint'(sh_v[3] & sh_last[3]));
    if (sh_v[3]) begin
      check("z_re", longint'(bus.z_re_o), sh_re[3]);
      check("z_im", longint'(bus.z_im_o), sh_im[3]);
      $display("txn cycle=%0d z=(%0d,%0d) last=%0b", cyc, bus.z_re_o, bus.z_im_o, bus.last_o);
    end
  endtask

  task automatic pass_through(input longint xre, input longint xim, input logic elast);
    cycle(1'b1, xre, xim, xre, xim, elast);
  endtask

  task automatic gap();
    cycle(1'b0, 12345, -999, 0, 0, 1'b0);
  endtask

  // Hold reset for some cycles with an optional beat offered meanwhile.
  task automatic do_reset(input int cycles, input logic v_during);
    rst_n       = 1'b0;
    bus.valid_i = v_during;
    bus.x_re_i  = DW'(777);
    bus.x_im_i  = DW'(777);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_i); #1;
      cyc++;
      check("rst_valid_o", longint'(bus.valid_o), 0);
      check("rst_last_o", longint'(bus.last_o), 0);
      check("rst_z_re", longint'(bus.z_re_o), 0);
      check("rst_z_im", longint'(bus.z_im_o), 0);
    end
    clear_expect();
    rst_n       = 1'b1;
    bus.valid_i = 1'b0;
  endtask

  function automatic longint clamp(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  // Reference: e = m*p with p = 0,2,1,3; W = cos - j sin; round half up; clamp.
  function automatic void model(input int n, input longint a, input longint b,
                                output longint zr, output longint zi);
    int     q, m, p, e;
    real    ang;
    longint c, s, r, im;
    q = n / 4;
    m = n % 4;
    p = (q == 0) ? 0 : (q == 1) ? 2 : (q == 2) ? 1 : 3;
    e = m * p;
    ang = 2.0 * 3.14159265358979 * real'(e) / real'(NN);
    c = longint'(256.0 * $cos(ang));
    s = longint'(256.0 * $sin(ang));
    r  = a * c + b * s;
    im = b * c - a * s;
    zr = clamp((r + 128) >>> 8);
    zi = clamp((im + 128) >>> 8);
  endfunction

  function automatic longint rnd_sample();
    logic signed [DW-1:0] t;
    int mode;
    mode = int'($urandom_range(0, 7));
    if (mode == 0) return MAXV;
    if (mode == 1) return MINV;
    t = DW'($urandom);
    return longint'(t);
  endfunction

  longint f2_xre [16] = '{11, 22, 33, 44, 77, MAXV, 0, 0, -1, 0, 0, 0, 31, 0, 0, 256};
  longint f2_xim [16] = '{-1, -2, -3, -4, -77, MAXV, 0, 0, 1, 0, 0, 0, -31, 0, 0, 0};
  longint f2_zre [16] = '{11, 22, 33, 44, 77, MAXV, 0, 0, -1, 0, 0, 0, 31, 0, 0, -237};
  longint f2_zim [16] = '{-1, -2, -3, -4, -77, 0, 0, 0, 1, 0, 0, 0, -31, 0, 0, 98};

  initial begin
    logic   v;
    longint a, b, zr, zi;
    int     tb_n, cnt;

    bus.valid_i = 1'b0;
    bus.x_re_i  = '0;
    bus.x_im_i  = '0;
    clear_expect();

    // Power-up reset.
    do_reset(3, 1'b0);

    // Frame 1, back to back: n=0..3 have e=0 and pass unchanged.
    for (int k = 0; k < 4; k++) pass_through(1000, -7, 1'b0);
    pass_through(123, -456, 1'b0);                 // n=4, e=0
    cycle(1'b1, 256, 0, 181, -181, 1'b0);          // n=5, e=2
    cycle(1'b1, 256, 0, 0, -256, 1'b0);            // n=6, e=4
    cycle(1'b1, 256, 0, -181, -181, 1'b0);         // n=7, e=6
    pass_through(-5, 9, 1'b0);                     // n=8, e=0
    cycle(1'b1, 100, 0, 93, -38, 1'b0);            // n=9, e=1
    cycle(1'b1, 0, 100, 71, 71, 1'b0);             // n=10, e=2
    cycle(1'b1, -256, -256, -335, 139, 1'b0);      // n=11, e=3
    pass_through(MAXV, MINV, 1'b0);                // n=12, e=0 extremes
    cycle(1'b1, 256, 0, 98, -237, 1'b0);           // n=13, e=3
    cycle(1'b1, MINV, MINV, 0, MAXV, 1'b0);        // n=14, e=6, im saturates
    cycle(1'b1, 100, 0, -93, 38, 1'b1);            // n=15, e=9, last

    // Frame 2, valid toggling 1010...; n=5 saturates re, n=15 carries last.
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, f2_xre[k], f2_xim[k], f2_zre[k], f2_zim[k], k == 15);
      gap();
    end

    // Frame 3: reset for one cycle after n=7 with a beat offered during it.
    for (int k = 0; k < 5; k++) pass_through(1000 + k, -k, 1'b0);
    cycle(1'b1, 256, 0, 181, -181, 1'b0);
    cycle(1'b1, 256, 0, 0, -256, 1'b0);
    cycle(1'b1, 256, 0, -181, -181, 1'b0);
    do_reset(1, 1'b1);
    pass_through(555, -444, 1'b0);                 // restarts at n=0
    for (int k = 1; k < 5; k++) pass_through(k, 2 * k, 1'b0);
    cycle(1'b1, 256, 0, 181, -181, 1'b0);          // n=5 after restart
    for (int k = 0; k < 4; k++) gap();

    // Random streams of 64 frames against the reference model.
    do_reset(2, 1'b0);
    tb_n = 0;
    cnt  = 0;
    while (cnt < 64 * NN) begin
      v = ($urandom_range(0, 3) != 0);
      a = rnd_sample();
      b = rnd_sample();
      if (v) begin
        model(tb_n, a, b, zr, zi);
        cycle(1'b1, a, b, zr, zi, tb_n == NN - 1);
        tb_n = (tb_n + 1) % NN;
        cnt++;
      end else begin
        cycle(1'b0, a, b, 0, 0, 1'b0);
      end
    end
    for (int k = 0; k < 4; k++) gap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_r22sdf_twiddle.md
FFT_R22SDF_TWIDDLE -- requirements
Module: fft_r22sdf_twiddle

Interface
REQ-001 Parameter DATA_WIDTH, default 25, SHALL set the signed width of the data inputs and outputs.
REQ-002 Parameter TWIDDLE_WIDTH, default 10, SHALL set the signed width of the cos and sin words; 1.0 is encoded as 2^(TWIDDLE_WIDTH-2).
REQ-003 Parameter N, default 1024, SHALL set the sub-transform length seen by this stage; N is a power of 4 and at least 16.
REQ-004 Port clk_i, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit, SHALL be a synchronous, active-low reset.
REQ-006 Port valid_i, input, 1 bit, SHALL qualify x_re_i and x_im_i; there is no backpressure.
REQ-007 Ports x_re_i and x_im_i, input, DATA_WIDTH signed, SHALL carry the butterfly-II output sample.
REQ-008 Ports z_re_o and z_im_o, output, DATA_WIDTH signed, SHALL carry the twiddled sample.
REQ-009 Port valid_o, output, 1 bit, SHALL qualify z_re_o and z_im_o.
REQ-010 Port last_o, output, 1 bit, SHALL mark the output of sample index n = N-1.

Function
REQ-011 Sample index n SHALL count valid_i beats modulo N: it starts at 0 after reset, increments only when valid_i=1, holds during gaps, and wraps from N-1 to 0.
REQ-012 Index decomposition SHALL be: q = n div (N/4), m = n mod (N/4).
REQ-013 Twiddle exponent SHALL be e = m*p, where p = 0, 2, 1, 3 for q = 0, 1, 2, 3 respectively (bit-reversed quadrant order).
REQ-014 Twiddle SHALL be W = cos(2*pi*e/N) - j*sin(2*pi*e/N), with each word stored as round(2^(TWIDDLE_WIDTH-2) * value); the ROM holds e = 0 to 3N/4-1.
REQ-015 Product SHALL be computed at full precision: re = a*c + b*s and im = b*c - a*s, where a = x_re, b = x_im, c = cos word, s = sin word.
REQ-016 Scaling SHALL be an arithmetic right shift by TWIDDLE_WIDTH-2 with round-half-up (add 2^(TWIDDLE_WIDTH-3) before the shift).
REQ-017 Results SHALL saturate symmetrically to [-(2^(DATA_WIDTH-1)), 2^(DATA_WIDTH-1)-1] and never wrap.
REQ-018 When e = 0, the output SHALL equal the input exactly.
REQ-019 Latency SHALL be a fixed 4 cycles from valid_i to valid_o, through these stages: input/index register, ROM read, multiply, add/round/saturate.
REQ-020 valid_o SHALL be valid_i delayed by exactly 4 cycles, including gaps; back-to-back input gives back-to-back output.
REQ-021 last_o SHALL be asserted only together with valid_o, for the sample whose n was N-1.
REQ-022 While valid_o=0, z_re_o and z_im_o are don't-care but SHALL NOT be X after reset.

Reset
REQ-023 When rst_n=0 at a clock edge, n SHALL be cleared to 0 and all pipeline valid bits, valid_o and last_o SHALL be cleared.
REQ-024 During reset, z_re_o and z_im_o SHALL be cleared to 0.
REQ-025 Reset mid-frame SHALL discard in-flight samples: no valid_o for them, and the first valid_i after release uses n = 0.
REQ-026 valid_i arriving in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-027 A shared fft package SHALL hold the twiddle-scale constant, the quadrant-permutation table {0, 2, 1, 3} and the latency constant (4).
REQ-028 Sub-module fft_twiddle_rom SHALL be used: 3N/4 entries, 1-cycle registered read, contents generated at elaboration from N and TWIDDLE_WIDTH.
REQ-029 Multipliers SHALL be plain signed products with registers placed to allow DSP inference.

Verification (N=16, DATA_WIDTH=25, TWIDDLE_WIDTH=10, so 1.0 = 256)
REQ-030 Apply x=(1000,-7) continuously for n=0..3 -> outputs (1000,-7) four cycles later, each with valid_o=1.
REQ-031 Apply x=(256,0) at n=5 (e=2, c=s=181) -> z=(181,-181); x=(256,0) at n=6 (e=4) -> z=(0,-256).
REQ-032 Apply x=(2^24-1, 2^24-1) at n=5 -> z_re saturates to 2^24-1 and z_im = 0.
REQ-033 Apply 16 samples with valid_i toggled 1010... -> valid_o reproduces the same pattern delayed by 4; n advances only on valid beats; last_o pulses once, on the 16th valid output.
REQ-034 Pull rst_n low for one cycle after n=7 while 3 samples are in flight -> those samples never appear on valid_o; the next sample is treated as n=0 and passes unchanged.
REQ-035 Drive random streams of 64 frames -> outputs match a bit-exact reference model implementing REQ-013 to REQ-017.
